// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder:
// FSM state encoding and the latency counter width.
package imem_pkg;

  localparam int LATENCY_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_sram.sv
// Simple dual-port word array: one synchronous write port and one registered read port.
// A read and a write to the same word on the same edge return the old word.
module imem_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**IDX_W];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Contents are deliberately never reset so a preloaded image survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; it holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder for the cache fill interface,
// with a preload side port for program images.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  addr_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic [31:0]           req_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [LATENCY_W-1:0] CNT_INIT = LATENCY_W'(LATENCY - 1);

  state_t                  state_reg, state_next;
  logic [LATENCY_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [31:0]             req_count_reg, req_count_next;
  logic                    ready_reg, ready_next;
  logic                    err_reg, err_next;
  logic                    oor_hold_reg, oor_hold_next;
  logic                    rd_en;
  logic                    req_oor;
  logic                    load_oor;
  logic [DATA_WIDTH-1:0]   sram_rdata;
  logic                    unused_addr_bits;

  assign req_oor  = |addr_reg[ADDR_WIDTH-1:IDX_W+2];
  assign load_oor = |load_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_bits = ^{mem_addr[1:0], load_addr[1:0], addr_reg[1:0]};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    req_count_next = req_count_reg;
    ready_next     = 1'b0;
    err_next       = 1'b0;
    oor_hold_next  = oor_hold_reg;
    rd_en          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          addr_next      = mem_addr;
          cnt_next       = CNT_INIT;
          req_count_next = req_count_reg + 32'd1;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          // Out-of-range responses skip the array and present zero instead.
          rd_en         = ~req_oor;
          ready_next    = 1'b1;
          err_next      = req_oor;
          oor_hold_next = req_oor;
          state_next    = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      req_count_reg <= '0;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      oor_hold_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      req_count_reg <= req_count_next;
      ready_reg     <= ready_next;
      err_reg       <= err_next;
      oor_hold_reg  <= oor_hold_next;
    end
  end

  imem_sram #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .we   (load_en & ~load_oor),
    .waddr(load_addr[IDX_W+1:2]),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(addr_reg[IDX_W+1:2]),
    .rdata(sram_rdata)
  );

  assign mem_data  = oor_hold_reg ? '0 : sram_rdata;
  assign mem_ready = ready_reg;
  assign addr_err  = err_reg;
  assign busy      = (state_reg != IDLE);
  assign req_count = req_count_reg;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, address handling, preload
// collisions, reset mid-request, and back-to-back requests at LATENCY=1.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data;
  logic        mem_ready, addr_err, busy;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] req_count;

  logic        mem_req1 = 1'b0;
  logic [31:0] mem_data1;
  logic        mem_ready1, addr_err1, busy1;
  logic [31:0] req_count1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(4096), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .addr_err(addr_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .req_count(req_count)
  );

  imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(4096), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(mem_req1), .mem_addr(32'h0000_0100),
    .mem_data(mem_data1), .mem_ready(mem_ready1), .addr_err(addr_err1),
    .load_en(1'b0), .load_addr(32'h0), .load_data(32'h0),
    .busy(busy1), .req_count(req_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    tick();
    load_en = 1'b0;
    $display("load addr=0x%08h data=0x%08h", addr, data);
  endtask

  // act: 0 none, 1 change mem_addr to 0x200, 2 load 0x12345678 @0x100, 3 reset.
  // act_cyc counts WAIT cycles after the accept edge (1 = first WAIT cycle).
  task automatic run_req(input logic [31:0] addr, input int act, input int act_cyc,
                         output int lat, output logic [31:0] data, output logic err,
                         output logic pulse_one, output logic busy_seen);
    lat = 0; data = '0; err = 1'b0; pulse_one = 1'b0;
    mem_req = 1'b1; mem_addr = addr;
    tick();
    mem_req = 1'b0;
    busy_seen = busy;
    for (int k = 1; k <= 12; k++) begin
      if (k == act_cyc) begin
        case (act)
          1: mem_addr = 32'h0000_0200;
          2: begin load_en = 1'b1; load_addr = 32'h0000_0100; load_data = 32'h1234_5678; end
          3: rst = 1'b1;
          default: ;
        endcase
      end
      tick();
      load_en = 1'b0;
      rst = 1'b0;
      if (mem_ready) begin
        lat = k; data = mem_data; err = addr_err;
        tick();
        pulse_one = ~mem_ready;
        break;
      end
    end
    $display("req addr=0x%08h act=%0d lat=%0d data=0x%08h err=%0b count=%0d",
             addr, act, lat, data, err, req_count);
  endtask

  int          lat;
  logic [31:0] data;
  logic        err, pulse_one, busy_seen;
  int          pulses, first_c;
  logic        prev, adj_ok;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", mem_ready, 0);
    check("rst_err", addr_err, 0);
    check("rst_data", mem_data, 0);
    check("rst_count", req_count, 0);
    check("rst_busy", busy, 0);

    load_word(32'h0000_0100, 32'hDEAD_BEEF);
    load_word(32'h0000_0200, 32'hCAFE_F00D);
    load_word(32'h0000_3FFC, 32'h0BAD_CAFE);

    run_req(32'h0000_0100, 0, 0, lat, data, err, pulse_one, busy_seen);
    check("basic_lat", lat, 4);
    check("basic_data", data, 32'hDEAD_BEEF);
    check("basic_err", err, 0);
    check("basic_pulse", pulse_one, 1);
    check("basic_busy", busy_seen, 1);
    check("basic_count", req_count, 1);
    check("basic_hold", mem_data, 32'hDEAD_BEEF);

    run_req(32'h0000_0103, 1, 2, lat, data, err, pulse_one, busy_seen);
    check("latch_data", data, 32'hDEAD_BEEF);
    check("latch_count", req_count, 2);

    run_req(32'h0000_4000, 0, 0, lat, data, err, pulse_one, busy_seen);
    check("oor_lat", lat, 4);
    check("oor_err", err, 1);
    check("oor_data", data, 0);
    check("oor_err_pulse", addr_err, 0);
    check("oor_data_hold", mem_data, 0);

    run_req(32'h0000_3FFC, 0, 0, lat, data, err, pulse_one, busy_seen);
    check("top_data", data, 32'h0BAD_CAFE);
    check("top_err", err, 0);

    run_req(32'h0000_0100, 2, 4, lat, data, err, pulse_one, busy_seen);
    check("rbw_old", data, 32'hDEAD_BEEF);
    load_word(32'h0000_0100, 32'hDEAD_BEEF);
    run_req(32'h0000_0100, 2, 2, lat, data, err, pulse_one, busy_seen);
    check("early_load_new", data, 32'h1234_5678);
    check("count5", req_count, 6);

    load_word(32'h0000_4100, 32'h0000_0BAD);

    run_req(32'h0000_0100, 3, 2, lat, data, err, pulse_one, busy_seen);
    check("rst_no_ready", lat, 0);
    check("rst_mid_count", req_count, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", mem_data, 0);

    run_req(32'h0000_0100, 0, 0, lat, data, err, pulse_one, busy_seen);
    check("preserve_data", data, 32'h1234_5678);
    check("preserve_count", req_count, 1);

    pulses = 0; first_c = 0; prev = 1'b0; adj_ok = 1'b1;
    mem_req1 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 30) mem_req1 = 1'b0;
      if (mem_ready1) begin
        pulses++;
        if (first_c == 0) first_c = c;
        if (prev) adj_ok = 1'b0;
      end
      prev = mem_ready1;
    end
    $display("b2b pulses=%0d first=%0d count=%0d", pulses, first_c, req_count1);
    check("b2b_first", first_c, 2);
    check("b2b_no_adjacent", adj_ok, 1);
    check("b2b_count", req_count1, pulses);
    check("b2b_many", (pulses >= 9), 1);
    check("b2b_idle", busy1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
